load_store_unit: RTL
====================

# load_store_unit

Parametrised load/store unit sitting between the MEM stage of the RV32I/RV64I pipeline and the data memory port. It replaces single-cycle, aligned-only data memory bindings with a handshaked, multi-cycle engine. The engine supports 32- or 64-bit data paths and splits misaligned accesses into two word beats. Loads are merged and sign/zero-extended; stores drive per-byte write strobes.

## Interface
Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: byte address width.
- MEM_AW, ADDR_W-$clog2(XLEN/8): word address width of the memory port.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  pipeline issues an access.
- req_ready  out  1  LSU idle; the request is accepted on req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_rd  in  5  destination register, returned with the response.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  illegal access; qualified by resp_valid.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_rd  out  5  echoed req_rd.
- mem_req  out  1  beat request.
- mem_gnt  in  1  memory accepts the beat.
- mem_we  out  1  beat is a write.
- mem_addr  out  MEM_AW  word address.
- mem_wstrb  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-aligned write data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.

## Operation
- Size in bytes: B=1, H=2, W=4, D=8.
- Offset = req_addr[log2(XLEN/8)-1:0].
- Illegal requests:
  - funct3 111, in any mode.
  - funct3 011 or 110 when XLEN=32.
  - Any store with funct3[2]=1.
  - An illegal request issues no memory beat and goes directly to RESP with resp_err=1.
- Split: when offset+size > XLEN/8, the access takes two beats. Beat 0 goes to word W=req_addr>>log2(XLEN/8). Beat 1 goes to W+1, modulo 2^MEM_AW, so the top word wraps to 0.
- Store lanes:
  - Full mask = ((1<<size)-1)<<offset, computed 2*XLEN/8 wide.
  - Beat 0 uses the low XLEN/8 bits of the mask; beat 1 uses the high bits.
  - Data = (req_wdata<<(8*offset)) over 2*XLEN bits; beat 0 takes the low half, beat 1 the high half.
- Loads: beat data is captured into a 2*XLEN buffer as {beat1, beat0}. The result is buffer>>(8*offset), truncated to size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to XLEN.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE: req_ready=1. On accept, register all request fields → REQ0, or → RESP if illegal.
  - REQ0/REQ1: mem_req=1. Address, we, strobe and data are held stable until mem_gnt.
  - On gnt, a load → WAITn. A store → REQ1 if split and in beat 0, else RESP.
  - WAITn: on mem_rvalid, capture data → REQ1 if split and in beat 0, else RESP.
  - RESP: resp_valid=1 for exactly one cycle → IDLE.
- mem_rvalid is ignored outside WAIT0/WAIT1.
- One beat is outstanding at most.

## Timing
- Reset (rst=0 at a clk edge) → IDLE. All outputs are 0: req_ready=0 during reset and 1 from the first cycle after rst returns high.
- Reset mid-operation aborts the operation with no response. A store whose beat 0 was already granted is left torn; this is permitted.
- mem_req is registered. It rises the cycle after accept.
- Earliest rvalid is the cycle after gnt. rvalid in the same cycle as gnt is a protocol error and is not supported.
- Aligned load, zero-wait memory: accept T, gnt T+1, rvalid T+2, resp_valid T+3.
- Aligned store: accept T, gnt T+1, resp_valid T+2.
- Split load: accept T, gnt T+1, rvalid T+2, gnt T+3, rvalid T+4, resp_valid T+5.
- Illegal request: accept T, resp_valid/resp_err T+1.
- resp_* are registered and held stable during the RESP cycle. req_ready=0 in RESP, so the next accept is earliest at resp_valid+1.
- Every extra cycle of gnt or rvalid delay adds exactly one cycle of latency.

## Test plan
- XLEN=32, LW at 0x100, mem word 0x0000_0040 = 0xDEADBEEF → mem_addr 0x40, resp_rdata 0xDEADBEEF at T+3.
- LH at 0x103, word 0x40 = 0x11xx_xxxx, word 0x41 = 0xxxxx_xx80 → two beats (0x40, 0x41), resp_rdata 0xFFFF8011. The same access as LHU → 0x00008011.
- SB 0xA5 at 0x102 → single beat, wstrb 0100, wdata 0x00A50000, resp_valid at T+2.
- SW 0x12345678 at 0x101 → beat 0: addr 0x40, wstrb 1110, wdata 0x34567800. Beat 1: addr 0x41, wstrb 0001, wdata 0x00000012.
- funct3 011 with XLEN=32, and SH with funct3 101 → no mem_req, resp_err=1 at T+1. XLEN=64, LD at offset 4 splits with wrap at top word → beat 1 addr 0.
- gnt delayed 3 cycles and reset asserted during WAIT0 → signals held stable while waiting, FSM returns to IDLE, a late rvalid is ignored, no resp_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// Handshaked load/store unit between the MEM stage and a word-wide data memory port.
// Misaligned accesses are split into two word beats; loads are merged and extended.
module load_store_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int MEM_AW = ADDR_W - $clog2(XLEN/8)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   input  logic [4:0]          req_rd,
   output logic                resp_valid,
   output logic                resp_err,
   output logic [XLEN-1:0]     resp_rdata,
   output logic [4:0]          resp_rd,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic                mem_we,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [XLEN/8-1:0]   mem_wstrb,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

   state_t              state_q, state_d;
   logic                we_q;
   logic [2:0]          funct3_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [XLEN-1:0]     wdata_q;
   logic [4:0]          rd_q;
   logic                err_q;
   logic [2*XLEN-1:0]   loadBuf_q, loadBuf_d;
   logic [XLEN-1:0]     respData_q, respData_d;

   logic                accept;
   logic                illegal;
   logic [OFFW-1:0]     offset;
   logic [3:0]          sizeBytes;
   logic                split;
   logic [MEM_AW-1:0]   word0;
   logic [7:0]          sizeMask;
   logic [2*NB-1:0]     fullMask;
   logic [2*XLEN-1:0]   fullData;
   logic [XLEN-1:0]     shifted;
   logic [XLEN-1:0]     keepMask;
   logic [XLEN-1:0]     loadValue;
   logic                signBit;
   logic                inBeat1;

   assign req_ready = rst && (state_q == IDLE);
   assign accept    = req_valid && req_ready;
   assign illegal   = (req_funct3 == 3'b111)
                   || ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)))
                   || (req_we && req_funct3[2]);

   assign offset    = addr_q[OFFW-1:0];
   assign sizeBytes = 4'd1 << funct3_q[1:0];
   assign split     = ({1'b0, 4'(offset)} + {1'b0, sizeBytes}) > 5'(NB);
   assign word0     = MEM_AW'(addr_q >> OFFW);
   assign inBeat1   = (state_q == REQ1);

   always_comb begin
      sizeMask = 8'hFF;
      case (funct3_q[1:0])
         2'b00:   sizeMask = 8'h01;
         2'b01:   sizeMask = 8'h03;
         2'b10:   sizeMask = 8'h0F;
         default: sizeMask = 8'hFF;
      endcase
   end

   // Lane mask and data span two words so the beat-1 half falls out of the high bits.
   assign fullMask = (2*NB)'(sizeMask) << offset;
   assign fullData = {{XLEN{1'b0}}, wdata_q} << {offset, 3'b000};

   assign mem_req   = (state_q == REQ0) || (state_q == REQ1);
   assign mem_we    = mem_req && we_q;
   assign mem_addr  = !mem_req ? '0 : (inBeat1 ? word0 + MEM_AW'(1) : word0);
   assign mem_wstrb = !mem_we ? '0 : (inBeat1 ? fullMask[2*NB-1:NB] : fullMask[NB-1:0]);
   assign mem_wdata = !mem_we ? '0 : (inBeat1 ? fullData[2*XLEN-1:XLEN] : fullData[XLEN-1:0]);

   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = resp_valid ? respData_q : '0;
   assign resp_rd    = resp_valid ? rd_q : '0;

   always_comb begin
      loadBuf_d = loadBuf_q;
      if (state_q == WAIT0 && mem_rvalid) loadBuf_d[XLEN-1:0] = mem_rdata;
      if (state_q == WAIT1 && mem_rvalid) loadBuf_d[2*XLEN-1:XLEN] = mem_rdata;
   end

   // Extraction works on the buffer value being written so the result registers on the last beat.
   always_comb begin
      shifted  = XLEN'(loadBuf_d >> {offset, 3'b000});
      keepMask = '1;
      signBit  = shifted[XLEN-1];
      case (funct3_q[1:0])
         2'b00: begin keepMask = XLEN'(8'hFF);         signBit = shifted[7];  end
         2'b01: begin keepMask = XLEN'(16'hFFFF);      signBit = shifted[15]; end
         2'b10: begin keepMask = XLEN'(32'hFFFF_FFFF); signBit = shifted[31]; end
         default: ;
      endcase
      loadValue = (shifted & keepMask) | (~keepMask & {XLEN{signBit && !funct3_q[2]}});
   end

   always_comb begin
      state_d    = state_q;
      respData_d = respData_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d    = illegal ? RESP : REQ0;
            respData_d = '0;
         end
         REQ0:  if (mem_gnt) state_d = !we_q ? WAIT0 : (split ? REQ1 : RESP);
         WAIT0: if (mem_rvalid) state_d = split ? REQ1 : RESP;
         REQ1:  if (mem_gnt) state_d = we_q ? RESP : WAIT1;
         WAIT1: if (mem_rvalid) state_d = RESP;
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if ((state_q == WAIT0 || state_q == WAIT1) && state_d == RESP) respData_d = loadValue;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         funct3_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         err_q      <= 1'b0;
         loadBuf_q  <= '0;
         respData_q <= '0;
      end else begin
         state_q    <= state_d;
         loadBuf_q  <= loadBuf_d;
         respData_q <= respData_d;
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
            err_q    <= illegal;
         end
      end
   end
endmodule
